// File: rtl/cdb_pkg.sv
// Shared widths, source encodings and the queued result record for the
// common data bus arbiter.
package cdb_pkg;

    localparam int XLEN     = 32;
    localparam int ROB_ID_W = 5;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [XLEN-1:0]     result;
        logic [XLEN-1:0]     target_pc;
        logic                jump;
    } cdb_entry;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source skid FIFO holding results until the bus grants them.
// DEPTH must be a power of two so the pointers wrap for free.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  cdb_entry din,
    output cdb_entry dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;
    cdb_entry      mem [DEPTH];

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU and LSU results onto a single broadcast
// bus, one result per cycle, with per-source skid FIFOs.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                valid_from_alu,
    input  logic [ROB_ID_W-1:0] rob_id_from_alu,
    input  logic [XLEN-1:0]     result_from_alu,
    input  logic [XLEN-1:0]     target_pc_from_alu,
    input  logic                jump_from_alu,
    output logic                full_to_alu,
    input  logic                valid_from_lsu,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsu,
    input  logic [XLEN-1:0]     result_from_lsu,
    output logic                full_to_lsu,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [XLEN-1:0]     cdb_result,
    output logic [XLEN-1:0]     cdb_target_pc,
    output logic                cdb_jump,
    output logic                cdb_src,
    output logic                overflow_err
);

    logic     active;
    logic     alu_req, lsu_req;
    logic     alu_push, lsu_push;
    logic     alu_pop, lsu_pop;
    logic     alu_empty, lsu_empty;
    logic     grant_valid, grant_lsu;
    logic     last_grant;
    cdb_entry alu_in, lsu_in, alu_head, lsu_head, head;

    assign active  = rdy_in && !flush_in;
    assign alu_req = active && valid_from_alu && (rob_id_from_alu != '0);
    assign lsu_req = active && valid_from_lsu && (rob_id_from_lsu != '0);

    // Full is judged on the pre-edge count, so a full FIFO never passes through.
    assign alu_push = alu_req && !full_to_alu;
    assign lsu_push = lsu_req && !full_to_lsu;

    assign grant_valid = active && (!alu_empty || !lsu_empty);
    assign grant_lsu   = !lsu_empty && (alu_empty || (last_grant == SRC_ALU));
    assign alu_pop     = grant_valid && !grant_lsu;
    assign lsu_pop     = grant_valid && grant_lsu;
    assign head        = grant_lsu ? lsu_head : alu_head;

    assign alu_in = '{rob_id: rob_id_from_alu, result: result_from_alu,
                      target_pc: target_pc_from_alu, jump: jump_from_alu};
    assign lsu_in = '{rob_id: rob_id_from_lsu, result: result_from_lsu,
                      target_pc: '0, jump: 1'b0};

    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .flush (flush_in),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   (alu_in),
        .dout  (alu_head),
        .full  (full_to_alu),
        .empty (alu_empty)
    );

    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .flush (flush_in),
        .push  (lsu_push),
        .pop   (lsu_pop),
        .din   (lsu_in),
        .dout  (lsu_head),
        .full  (full_to_lsu),
        .empty (lsu_empty)
    );

    // last_grant resets to LSU so the ALU wins the first tie.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid     <= 1'b0;
            cdb_rob_id    <= '0;
            cdb_result    <= '0;
            cdb_target_pc <= '0;
            cdb_jump      <= 1'b0;
            cdb_src       <= SRC_ALU;
            overflow_err  <= 1'b0;
            last_grant    <= SRC_LSU;
        end else begin
            if ((alu_req && full_to_alu) || (lsu_req && full_to_lsu))
                overflow_err <= 1'b1;
            if (flush_in) begin
                cdb_valid <= 1'b0;
            end else if (rdy_in) begin
                if (grant_valid) begin
                    cdb_valid     <= 1'b1;
                    cdb_rob_id    <= head.rob_id;
                    cdb_result    <= head.result;
                    cdb_target_pc <= head.target_pc;
                    cdb_jump      <= head.jump;
                    cdb_src       <= grant_lsu;
                    last_grant    <= grant_lsu;
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts queued as stimulus is
// driven, popped and compared whenever a new broadcast appears.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        valid_from_alu = 1'b0;
    logic [4:0]  rob_id_from_alu = '0;
    logic [31:0] result_from_alu = '0;
    logic [31:0] target_pc_from_alu = '0;
    logic        jump_from_alu = 1'b0;
    logic        full_to_alu;
    logic        valid_from_lsu = 1'b0;
    logic [4:0]  rob_id_from_lsu = '0;
    logic [31:0] result_from_lsu = '0;
    logic        full_to_lsu;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_result;
    logic [31:0] cdb_target_pc;
    logic        cdb_jump;
    logic        cdb_src;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        src;
        logic [4:0]  id;
        logic [31:0] res;
        logic [31:0] tpc;
        logic        jmp;
    } exp_t;

    exp_t sb[$];

    cdb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .flush_in           (flush_in),
        .valid_from_alu     (valid_from_alu),
        .rob_id_from_alu    (rob_id_from_alu),
        .result_from_alu    (result_from_alu),
        .target_pc_from_alu (target_pc_from_alu),
        .jump_from_alu      (jump_from_alu),
        .full_to_alu        (full_to_alu),
        .valid_from_lsu     (valid_from_lsu),
        .rob_id_from_lsu    (rob_id_from_lsu),
        .result_from_lsu    (result_from_lsu),
        .full_to_lsu        (full_to_lsu),
        .cdb_valid          (cdb_valid),
        .cdb_rob_id         (cdb_rob_id),
        .cdb_result         (cdb_result),
        .cdb_target_pc      (cdb_target_pc),
        .cdb_jump           (cdb_jump),
        .cdb_src            (cdb_src),
        .overflow_err       (overflow_err)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] alu_res(input logic [4:0] id);
        return 32'hA000_0000 | 32'(id);
    endfunction

    function automatic logic [31:0] alu_tpc(input logic [4:0] id);
        return 32'h0000_4000 | (32'(id) << 4);
    endfunction

    function automatic logic [31:0] lsu_res(input logic [4:0] id);
        return 32'h5500_0000 | 32'(id);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_alu(input logic [4:0] id);
        valid_from_alu     = 1'b1;
        rob_id_from_alu    = id;
        result_from_alu    = alu_res(id);
        target_pc_from_alu = alu_tpc(id);
        jump_from_alu      = id[0];
    endtask

    task automatic drive_lsu(input logic [4:0] id);
        valid_from_lsu  = 1'b1;
        rob_id_from_lsu = id;
        result_from_lsu = lsu_res(id);
    endtask

    task automatic clear_alu();
        valid_from_alu  = 1'b0;
        rob_id_from_alu = '0;
    endtask

    task automatic clear_lsu();
        valid_from_lsu  = 1'b0;
        rob_id_from_lsu = '0;
    endtask

    task automatic idle();
        clear_alu();
        clear_lsu();
    endtask

    task automatic exp_alu(input logic [4:0] id);
        sb.push_back(exp_t'{1'b0, id, alu_res(id), alu_tpc(id), id[0]});
    endtask

    task automatic exp_lsu(input logic [4:0] id);
        sb.push_back(exp_t'{1'b1, id, lsu_res(id), 32'h0, 1'b0});
    endtask

    // One clock; a new broadcast is checked against the scoreboard head.
    task automatic step();
        logic eff;
        exp_t e;
        eff = rdy_in && !flush_in && rst_in;
        @(posedge clk_in);
        #1;
        if (eff && cdb_valid) begin
            chk("bcast_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("bcast_src", 32'(cdb_src), 32'(e.src));
                chk("bcast_rob_id", 32'(cdb_rob_id), 32'(e.id));
                chk("bcast_result", cdb_result, e.res);
                chk("bcast_target_pc", cdb_target_pc, e.tpc);
                chk("bcast_jump", 32'(cdb_jump), 32'(e.jmp));
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) step();
    endtask

    task automatic do_reset();
        idle();
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        rst_in   = 1'b0;
        #1;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_rob_id", 32'(cdb_rob_id), 32'd0);
        chk("rst_cdb_result", cdb_result, 32'd0);
        chk("rst_cdb_target_pc", cdb_target_pc, 32'd0);
        chk("rst_cdb_jump", 32'(cdb_jump), 32'd0);
        chk("rst_cdb_src", 32'(cdb_src), 32'd0);
        chk("rst_overflow_err", 32'(overflow_err), 32'd0);
        chk("rst_full_to_alu", 32'(full_to_alu), 32'd0);
        chk("rst_full_to_lsu", 32'(full_to_lsu), 32'd0);
        sb.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [4:0] aids [3];
        logic [4:0] lids [3];
        int ai;
        int li;
        logic acc_a;
        logic acc_l;
        aids = '{5'd1, 5'd2, 5'd3};
        lids = '{5'd6, 5'd7, 5'd8};

        #1;
        do_reset();

        // Single ALU result, no contention: visible one edge after enqueue.
        drive_alu(5'd3);
        result_from_alu = 32'h55;
        sb.push_back(exp_t'{1'b0, 5'd3, 32'h55, alu_tpc(5'd3), 1'b1});
        step();
        chk("t1_valid_edge1", 32'(cdb_valid), 32'd0);
        idle();
        step();
        chk("t1_valid_edge2", 32'(cdb_valid), 32'd1);
        chk("t1_rob_edge2", 32'(cdb_rob_id), 32'd3);
        chk("t1_result_edge2", cdb_result, 32'h55);
        chk("t1_src_edge2", 32'(cdb_src), 32'd0);
        step();
        chk("t1_valid_edge3", 32'(cdb_valid), 32'd0);
        chk("t1_rob_hold", 32'(cdb_rob_id), 32'd3);

        // Tag 0 is silently ignored on both sources.
        valid_from_alu = 1'b1;
        valid_from_lsu = 1'b1;
        step();
        idle();
        step();
        step();
        chk("t1_tag0_no_bcast", 32'(cdb_valid), 32'd0);
        chk("t1_tag0_no_ovf", 32'(overflow_err), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Round-robin from reset: 1(ALU), 2(LSU), 4(ALU), 5(LSU).
        do_reset();
        exp_alu(5'd1);
        exp_lsu(5'd2);
        exp_alu(5'd4);
        exp_lsu(5'd5);
        drive_alu(5'd1);
        drive_lsu(5'd2);
        step();
        drive_alu(5'd4);
        drive_lsu(5'd5);
        step();
        idle();
        drain(8);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure with a producer that honours full; last grant is ALU.
        exp_alu(5'd10);
        drive_alu(5'd10);
        step();
        idle();
        step();
        exp_lsu(5'd6);
        exp_alu(5'd1);
        exp_lsu(5'd7);
        exp_alu(5'd2);
        exp_lsu(5'd8);
        exp_alu(5'd3);
        ai = 0;
        li = 0;
        for (int c = 0; c < 10; c++) begin
            if (ai < 3 && !full_to_alu) drive_alu(aids[ai]); else clear_alu();
            if (li < 3 && !full_to_lsu) drive_lsu(lids[li]); else clear_lsu();
            acc_a = valid_from_alu;
            acc_l = valid_from_lsu;
            step();
            if (acc_a) ai++;
            if (acc_l) li++;
            if (c == 1) chk("t3_full_alu_count2", 32'(full_to_alu), 32'd1);
            if (c == 2) chk("t3_alu3_held", 32'(ai), 32'd2);
        end
        idle();
        drain(6);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_alu_all_sent", 32'(ai), 32'd3);
        chk("t3_lsu_all_sent", 32'(li), 32'd3);
        chk("t3_no_overflow", 32'(overflow_err), 32'd0);

        // Valid while full is dropped and sets the sticky error.
        exp_lsu(5'd14);
        exp_alu(5'd11);
        exp_lsu(5'd15);
        exp_alu(5'd12);
        drive_alu(5'd11);
        drive_lsu(5'd14);
        step();
        drive_alu(5'd12);
        drive_lsu(5'd15);
        step();
        chk("t4_full_alu", 32'(full_to_alu), 32'd1);
        chk("t4_ovf_before", 32'(overflow_err), 32'd0);
        drive_alu(5'd13);
        clear_lsu();
        step();
        chk("t4_ovf_set", 32'(overflow_err), 32'd1);
        idle();
        drain(8);
        step();
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow_err), 32'd1);

        // Flush discards queued entries and the same-cycle input.
        do_reset();
        drive_alu(5'd1);
        drive_lsu(5'd2);
        step();
        flush_in = 1'b1;
        clear_alu();
        drive_lsu(5'd9);
        step();
        chk("t5_valid_after_flush", 32'(cdb_valid), 32'd0);
        chk("t5_full_alu", 32'(full_to_alu), 32'd0);
        chk("t5_full_lsu", 32'(full_to_lsu), 32'd0);
        flush_in = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("t5_no_bcast", 32'(cdb_valid), 32'd0);
        exp_alu(5'd3);
        exp_lsu(5'd4);
        drive_alu(5'd3);
        drive_lsu(5'd4);
        step();
        idle();
        drain(6);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // rdy_in low freezes everything, then resumes in order.
        exp_alu(5'd5);
        exp_lsu(5'd6);
        exp_alu(5'd7);
        exp_lsu(5'd8);
        drive_alu(5'd5);
        drive_lsu(5'd6);
        step();
        drive_alu(5'd7);
        drive_lsu(5'd8);
        step();
        rdy_in = 1'b0;
        drive_alu(5'd9);
        drive_lsu(5'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_hold_valid", 32'(cdb_valid), 32'd1);
            chk("t6_hold_rob", 32'(cdb_rob_id), 32'd5);
            chk("t6_hold_full_lsu", 32'(full_to_lsu), 32'd1);
            chk("t6_hold_full_alu", 32'(full_to_alu), 32'd0);
        end
        rdy_in = 1'b1;
        idle();
        drain(8);
        step();
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-operation drops pending entries.
        drive_alu(5'd10);
        drive_lsu(5'd11);
        step();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        chk("t7_no_bcast", 32'(cdb_valid), 32'd0);
        exp_alu(5'd12);
        drive_alu(5'd12);
        step();
        idle();
        drain(4);
        chk("t7_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
